// File: rtl/sp_ram_ctrl_pkg.sv
// Shared types and constants for the single-port RAM burst controller.
package sp_ram_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WRITE  = 2'd1,
        READ   = 2'd2,
        FINISH = 2'd3
    } ctrl_state_e;

    localparam int SKID_DEPTH = 2;

    // One extra bit so a full-memory burst length is representable.
    function automatic int len_width(input int addr_width);
        return addr_width + 1;
    endfunction

endpackage

// File: rtl/ram_read_skid_buffer.sv
// Two-entry FIFO that catches RAM read data so downstream backpressure
// never loses a word already in the RAM pipeline.
module ram_read_skid_buffer
    import sp_ram_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic                  empty,
    output logic                  full,
    output logic [1:0]            count
);

    logic [DATA_WIDTH-1:0] mem_r [SKID_DEPTH];
    logic                  wr_ptr_r;
    logic                  rd_ptr_r;
    logic [1:0]            count_r;
    logic                  push_ok_s;
    logic                  pop_ok_s;

    assign pop_ok_s  = pop && (count_r != 2'd0);
    assign push_ok_s = push && ((count_r != 2'(SKID_DEPTH)) || pop_ok_s);

    // Storage, pointers and occupancy; storage itself needs no reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= ~wr_ptr_r;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            count_r <= count_r + {1'b0, push_ok_s} - {1'b0, pop_ok_s};
        end
    end

    assign head_data = mem_r[rd_ptr_r];
    assign empty     = (count_r == 2'd0);
    assign full      = (count_r == 2'(SKID_DEPTH));
    assign count     = count_r;

endmodule

// File: rtl/sp_ram_burst_ctrl.sv
// Burst controller owning the single-port RAM pins: streams write bursts into
// the RAM and read bursts out through a skid buffer that hides read latency.
module sp_ram_burst_ctrl
    import sp_ram_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int LEN_WIDTH  = len_width(ADDR_WIDTH)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  CMD_VALID,
    output logic                  CMD_READY,
    input  logic                  CMD_WRITE,
    input  logic [ADDR_WIDTH-1:0] CMD_ADDR,
    input  logic [LEN_WIDTH-1:0]  CMD_LEN,
    input  logic [DATA_WIDTH-1:0] WR_DATA,
    input  logic                  WR_VALID,
    output logic                  WR_READY,
    output logic [DATA_WIDTH-1:0] RD_DATA,
    output logic                  RD_VALID,
    input  logic                  RD_READY,
    output logic                  DONE,
    output logic [ADDR_WIDTH-1:0] RAM_ADDR,
    output logic [DATA_WIDTH-1:0] RAM_D,
    output logic                  RAM_WE,
    input  logic [DATA_WIDTH-1:0] RAM_Q
);

    ctrl_state_e           state_r;
    ctrl_state_e           state_nxt_s;
    logic [ADDR_WIDTH-1:0] ptr_r;
    logic [LEN_WIDTH-1:0]  issue_cnt_r;
    logic [LEN_WIDTH-1:0]  pop_cnt_r;
    logic                  inflight_r;
    logic                  issue_s;
    logic                  pop_s;
    logic                  wr_beat_s;
    logic                  cmd_take_s;
    logic [2:0]            pending_s;
    logic [1:0]            occ_s;
    logic                  empty_s;
    logic                  full_s;
    logic [DATA_WIDTH-1:0] head_s;

    // Handshakes and read issue; pending counts the word already inside the RAM.
    always_comb begin
        cmd_take_s = (state_r == IDLE) && CMD_VALID;
        wr_beat_s  = (state_r == WRITE) && WR_VALID;
        pop_s      = (state_r == READ) && !empty_s && RD_READY;
        pending_s  = {1'b0, occ_s} + {2'b00, inflight_r} - {2'b00, pop_s};
        issue_s    = (state_r == READ) && (issue_cnt_r != {LEN_WIDTH{1'b0}})
                     && (pending_s < 3'd2) && !(full_s && !pop_s);
    end

    // Next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (!CMD_VALID) begin
                    state_nxt_s = IDLE;
                end else if (CMD_LEN == {LEN_WIDTH{1'b0}}) begin
                    state_nxt_s = FINISH;
                end else if (CMD_WRITE) begin
                    state_nxt_s = WRITE;
                end else begin
                    state_nxt_s = READ;
                end
            end
            WRITE: begin
                if (wr_beat_s && (issue_cnt_r == LEN_WIDTH'(1))) begin
                    state_nxt_s = FINISH;
                end else begin
                    state_nxt_s = WRITE;
                end
            end
            READ: begin
                if (pop_s && (pop_cnt_r == LEN_WIDTH'(1))) begin
                    state_nxt_s = FINISH;
                end else begin
                    state_nxt_s = READ;
                end
            end
            FINISH:  state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // State, address pointer, burst counters and the read-in-flight flag.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r     <= IDLE;
            ptr_r       <= {ADDR_WIDTH{1'b0}};
            issue_cnt_r <= {LEN_WIDTH{1'b0}};
            pop_cnt_r   <= {LEN_WIDTH{1'b0}};
            inflight_r  <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            inflight_r <= issue_s;
            if (cmd_take_s) begin
                ptr_r       <= CMD_ADDR;
                issue_cnt_r <= CMD_LEN;
                pop_cnt_r   <= CMD_LEN;
            end else begin
                if (wr_beat_s || issue_s) begin
                    ptr_r       <= ptr_r + ADDR_WIDTH'(1);
                    issue_cnt_r <= issue_cnt_r - LEN_WIDTH'(1);
                end
                if (pop_s) begin
                    pop_cnt_r <= pop_cnt_r - LEN_WIDTH'(1);
                end
            end
        end
    end

    ram_read_skid_buffer #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_skid (
        .CLK      (CLK),
        .RST      (RST),
        .push     (inflight_r),
        .push_data(RAM_Q),
        .pop      (pop_s),
        .head_data(head_s),
        .empty    (empty_s),
        .full     (full_s),
        .count    (occ_s)
    );

    assign CMD_READY = (state_r == IDLE);
    assign WR_READY  = (state_r == WRITE);
    assign DONE      = (state_r == FINISH);
    assign RAM_WE    = wr_beat_s;
    assign RAM_ADDR  = ptr_r;
    assign RAM_D     = WR_DATA;
    assign RD_VALID  = !empty_s;
    assign RD_DATA   = empty_s ? {DATA_WIDTH{1'b0}} : head_s;

endmodule

// File: tb/tb_sp_ram_burst_ctrl.sv
// Directed bench for sp_ram_burst_ctrl: a write-first RAM model, a
// transaction-level reference model and a per-cycle compare process.
module tb_sp_ram_burst_ctrl;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int LW = 5;

    logic          CLK = 1'b0;
    logic          RST;
    logic          CMD_VALID;
    logic          CMD_READY;
    logic          CMD_WRITE;
    logic [AW-1:0] CMD_ADDR;
    logic [LW-1:0] CMD_LEN;
    logic [DW-1:0] WR_DATA;
    logic          WR_VALID;
    logic          WR_READY;
    logic [DW-1:0] RD_DATA;
    logic          RD_VALID;
    logic          RD_READY;
    logic          DONE;
    logic [AW-1:0] RAM_ADDR;
    logic [DW-1:0] RAM_D;
    logic          RAM_WE;
    logic [DW-1:0] RAM_Q;

    always #5 CLK = ~CLK;

    sp_ram_burst_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
        .CLK(CLK), .RST(RST),
        .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_WRITE(CMD_WRITE),
        .CMD_ADDR(CMD_ADDR), .CMD_LEN(CMD_LEN),
        .WR_DATA(WR_DATA), .WR_VALID(WR_VALID), .WR_READY(WR_READY),
        .RD_DATA(RD_DATA), .RD_VALID(RD_VALID), .RD_READY(RD_READY),
        .DONE(DONE), .RAM_ADDR(RAM_ADDR), .RAM_D(RAM_D), .RAM_WE(RAM_WE), .RAM_Q(RAM_Q)
    );

    // Write-first single-port RAM with registered address.
    logic [DW-1:0] ram [16];
    always @(posedge CLK) begin
        if (RAM_WE) ram[RAM_ADDR] <= RAM_D;
        RAM_Q <= RAM_WE ? RAM_D : ram[RAM_ADDR];
    end

    // Reference model: memory image plus expected write/read/done streams.
    logic [DW-1:0]      shadow [16];
    logic [AW+DW-1:0]   exp_wr_q [$];
    logic [DW-1:0]      exp_rd_q [$];
    int                 exp_done;
    int                 total;
    int                 bad;
    logic [DW-1:0]      wbuf [16];
    logic [AW-1:0]      obs_addr [16];
    logic [DW-1:0]      rx [32];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Per-cycle compare against the model streams.
    initial begin
        logic            stall;
        int              stall_data;
        logic [AW+DW-1:0] e;
        logic [DW-1:0]   d;
        stall = 1'b0;
        stall_data = 0;
        forever begin
            @(negedge CLK);
            if (RST) begin
                stall = 1'b0;
            end else begin
                if (stall) begin
                    check("rd_hold_valid", int'(RD_VALID), 1);
                    check("rd_hold_data", int'(RD_DATA), stall_data);
                end
                if (RAM_WE) begin
                    check("we_expected", int'(exp_wr_q.size() > 0), 1);
                    if (exp_wr_q.size() > 0) begin
                        e = exp_wr_q.pop_front();
                        check("we_addr", int'(RAM_ADDR), int'(e[AW+DW-1:DW]));
                        check("we_data", int'(RAM_D), int'(e[DW-1:0]));
                    end
                end
                if (RD_VALID && RD_READY) begin
                    check("rd_expected", int'(exp_rd_q.size() > 0), 1);
                    if (exp_rd_q.size() > 0) begin
                        d = exp_rd_q.pop_front();
                        check("rd_data", int'(RD_DATA), int'(d));
                    end
                end
                if (DONE) begin
                    check("done_expected", int'(exp_done > 0), 1);
                    if (exp_done > 0) exp_done--;
                end
                check("wr_rd_exclusive", int'(WR_READY && RD_VALID), 0);
                stall = RD_VALID && !RD_READY;
                stall_data = int'(RD_DATA);
            end
        end
    end

    task automatic write_burst(input logic [AW-1:0] addr, input int len);
        logic [AW-1:0] a;
        CMD_VALID = 1'b1; CMD_WRITE = 1'b1; CMD_ADDR = addr; CMD_LEN = LW'(len);
        for (int i = 0; i < len; i++) begin
            a = addr + AW'(i);
            exp_wr_q.push_back({a, wbuf[i]});
            shadow[a] = wbuf[i];
        end
        exp_done++;
        tick();
        CMD_VALID = 1'b0;
        for (int i = 0; i < len; i++) begin
            WR_VALID = 1'b1;
            WR_DATA  = wbuf[i];
            @(negedge CLK);
            check("wr_ready", int'(WR_READY), 1);
            check("wr_we_beat", int'(RAM_WE), 1);
            obs_addr[i] = RAM_ADDR;
            tick();
        end
        WR_VALID = 1'b0;
        @(negedge CLK);
        check("wr_done_pulse", int'(DONE), 1);
        check("wr_we_after", int'(RAM_WE), 0);
        tick();
        @(negedge CLK);
        check("wr_done_single", int'(DONE), 0);
        check("wr_cmd_ready", int'(CMD_READY), 1);
        check("wr_stream_drained", exp_wr_q.size(), 0);
        tick();
    endtask

    task automatic read_burst(input logic [AW-1:0] addr, input int len,
                              input logic [15:0] pat, input int pat_len,
                              output int first_k, output int done_k, output int nrx);
        CMD_VALID = 1'b1; CMD_WRITE = 1'b0; CMD_ADDR = addr; CMD_LEN = LW'(len);
        for (int i = 0; i < len; i++) exp_rd_q.push_back(shadow[addr + AW'(i)]);
        exp_done++;
        RD_READY = 1'b1;
        tick();
        CMD_VALID = 1'b0;
        first_k = -1; done_k = -1; nrx = 0;
        for (int k = 0; k < 60 && done_k < 0; k++) begin
            if (k >= 2 && (k - 2) < pat_len) RD_READY = pat[k-2];
            else RD_READY = 1'b1;
            @(negedge CLK);
            if (RD_VALID && first_k < 0) first_k = k;
            if (RD_VALID && RD_READY && nrx < 32) begin
                rx[nrx] = RD_DATA;
                nrx++;
            end
            if (DONE) done_k = k;
            tick();
        end
        RD_READY = 1'b0;
        check("rd_done_seen", int'(done_k >= 0), 1);
        check("rd_count", nrx, len);
        check("rd_stream_drained", exp_rd_q.size(), 0);
    endtask

    initial begin
        int fk, dk, n;
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int fk, dk, n;
        total = 0; bad = 0; exp_done = 0;
        RST = 1'b1; CMD_VALID = 1'b0; CMD_WRITE = 1'b0; CMD_ADDR = '0; CMD_LEN = '0;
        WR_DATA = '0; WR_VALID = 1'b0; RD_READY = 1'b0;
        tick(); tick();
        @(negedge CLK);
        check("rst_cmd_ready", int'(CMD_READY), 1);
        check("rst_wr_ready", int'(WR_READY), 0);
        check("rst_rd_valid", int'(RD_VALID), 0);
        check("rst_done", int'(DONE), 0);
        check("rst_we", int'(RAM_WE), 0);
        check("rst_ram_addr", int'(RAM_ADDR), 0);
        check("rst_rd_data", int'(RD_DATA), 0);
        tick();
        RST = 1'b0;

        // Write A0..A3 at address 2.
        for (int i = 0; i < 4; i++) wbuf[i] = 8'hA0 + 8'(i);
        write_burst(4'd2, 4);
        check("wr_addr0", int'(obs_addr[0]), 2);
        check("wr_addr3", int'(obs_addr[3]), 5);
        check("ram2", int'(ram[2]), 8'hA0);
        check("ram5", int'(ram[5]), 8'hA3);

        // Plain read with RD_READY held.
        read_burst(4'd2, 4, 16'h0000, 0, fk, dk, n);
        check("rd_first_latency", fk, 2);
        check("rd_done_cycle", dk, 6);
        check("rd_word0", int'(rx[0]), 8'hA0);
        check("rd_word1", int'(rx[1]), 8'hA1);
        check("rd_word2", int'(rx[2]), 8'hA2);
        check("rd_word3", int'(rx[3]), 8'hA3);

        // Backpressure: ready 1,0,0,1,0,1,1 from the first valid cycle.
        read_burst(4'd2, 4, 16'h0069, 7, fk, dk, n);
        check("bp_first_latency", fk, 2);
        check("bp_word0", int'(rx[0]), 8'hA0);
        check("bp_word1", int'(rx[1]), 8'hA1);
        check("bp_word2", int'(rx[2]), 8'hA2);
        check("bp_word3", int'(rx[3]), 8'hA3);

        // Wrap-around write 1..4 at 14, then immediate readback.
        for (int i = 0; i < 4; i++) wbuf[i] = 8'(i + 1);
        write_burst(4'd14, 4);
        check("wrap_addr0", int'(obs_addr[0]), 14);
        check("wrap_addr1", int'(obs_addr[1]), 15);
        check("wrap_addr2", int'(obs_addr[2]), 0);
        check("wrap_addr3", int'(obs_addr[3]), 1);
        read_burst(4'd14, 4, 16'h0000, 0, fk, dk, n);
        check("wrap_rd0", int'(rx[0]), 1);
        check("wrap_rd3", int'(rx[3]), 4);

        // Zero-length command goes straight to FINISH.
        CMD_VALID = 1'b1; CMD_WRITE = 1'b0; CMD_ADDR = 4'd7; CMD_LEN = 5'd0;
        exp_done++;
        tick();
        CMD_VALID = 1'b0;
        @(negedge CLK);
        check("len0_done", int'(DONE), 1);
        check("len0_cmd_ready", int'(CMD_READY), 0);
        check("len0_we", int'(RAM_WE), 0);
        check("len0_rd_valid", int'(RD_VALID), 0);
        tick();
        @(negedge CLK);
        check("len0_idle", int'(CMD_READY), 1);
        check("len0_done_single", int'(DONE), 0);
        tick();

        // Reset while one read word is buffered.
        CMD_VALID = 1'b1; CMD_WRITE = 1'b0; CMD_ADDR = 4'd2; CMD_LEN = 5'd4;
        RD_READY = 1'b0;
        tick();
        CMD_VALID = 1'b0;
        tick(); tick();
        RST = 1'b1;
        @(negedge CLK);
        check("mid_rd_valid_before", int'(RD_VALID), 1);
        tick();
        RST = 1'b0;
        @(negedge CLK);
        check("mid_rst_rd_valid", int'(RD_VALID), 0);
        check("mid_rst_done", int'(DONE), 0);
        check("mid_rst_cmd_ready", int'(CMD_READY), 1);
        tick();
        read_burst(4'd2, 4, 16'h0000, 0, fk, dk, n);
        check("post_rst_rd0", int'(rx[0]), 8'hA0);
        check("post_rst_rd3", int'(rx[3]), 8'hA3);

        // Full-memory burst (length 16) starting mid-array.
        for (int i = 0; i < 16; i++) wbuf[i] = 8'h30 + 8'(i);
        write_burst(4'd5, 16);
        check("full_addr15", int'(obs_addr[15]), 4);
        read_burst(4'd5, 16, 16'h0000, 0, fk, dk, n);
        check("full_done_cycle", dk, 18);
        check("full_rd0", int'(rx[0]), 8'h30);
        check("full_rd15", int'(rx[15]), 8'h3F);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
